// File: rtl/quat_sync_sink_if.sv
`default_nettype none
// ============================================================================
// quat_sync_sink_if : quaternary link rails plus the decoded valid/ready bus
// Revision: 1.0
// ============================================================================
interface quat_sync_sink_if;
  logic [3:0] quat_in;
  logic       quat_comp;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output quat_in,
    output out_ready,
    input  quat_comp,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  quat_in,
    input  out_ready,
    output quat_comp,
    output out_data,
    output out_valid
  );
endinterface
`default_nettype wire

// File: rtl/quat_sync_sink.sv
`default_nettype none
// ============================================================================
// quat_sync_sink : 1-of-4 NCL wavefront receiver with completion and FWFT FIFO
// Revision: 1.0
// ============================================================================
module quat_sync_sink #(
  parameter int DEPTH  = 4,
  parameter int STABLE = 2,
  parameter int CNT_W  = 16
) (
  input  wire logic                    clk,
  input  wire logic                    init_n,
  quat_sync_sink_if.slave              lnk,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic                         err_illegal,
  output logic [CNT_W-1:0]             wave_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STABLE + 1);
  localparam logic [SW-1:0] C_STABLE_CNT = SW'(STABLE);
  localparam logic [AW:0]   C_FULL_LVL   = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_comp;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_prev;
  logic [SW-1:0] r_stab_cnt;
  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;

  logic          w_stable;
  logic          w_zero;
  logic          w_onehot;
  logic          w_full;
  logic          w_deq;
  logic          w_enq;
  logic [1:0]    w_code;

  // r_prev is the pattern under observation; r_stab_cnt counts how long it has held
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_sync1    <= 4'd0;
      r_sync2    <= 4'd0;
      r_prev     <= 4'd0;
      r_stab_cnt <= '0;
    end else begin
      r_sync1 <= lnk.quat_in;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_prev) begin
        r_prev     <= r_sync2;
        r_stab_cnt <= SW'(1);
      end else if (r_stab_cnt != C_STABLE_CNT) begin
        r_stab_cnt <= r_stab_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_code = 2'd0;
    case (r_prev)
      4'b0010: w_code = 2'd1;
      4'b0100: w_code = 2'd2;
      4'b1000: w_code = 2'd3;
      default: w_code = 2'd0;
    endcase
  end

  assign w_stable = (r_stab_cnt == C_STABLE_CNT);
  assign w_zero   = (r_prev == 4'd0);
  assign w_onehot = $onehot(r_prev);
  assign w_full   = (r_level == C_FULL_LVL);
  assign w_deq    = (r_level != '0) && lnk.out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign w_enq    = (r_state == WAIT_DATA) && w_stable && w_onehot && (!w_full || w_deq);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_state     <= WAIT_DATA;
      r_comp      <= 1'b0;
      err_illegal <= 1'b0;
      wave_cnt    <= '0;
    end else begin
      case (r_state)
        WAIT_DATA: begin
          if (w_enq) begin
            r_state  <= WAIT_NULL;
            r_comp   <= 1'b1;
            wave_cnt <= wave_cnt + 1'b1;
          end else if (w_stable && !w_zero && !w_onehot) begin
            // Drop the illegal wavefront but keep the handshake moving
            r_state     <= WAIT_NULL;
            r_comp      <= 1'b1;
            err_illegal <= 1'b1;
          end
        end
        WAIT_NULL: begin
          if (w_stable && w_zero) begin
            r_state <= WAIT_DATA;
            r_comp  <= 1'b0;
          end
        end
        default: begin
          r_state <= WAIT_DATA;
          r_comp  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 2'd0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_enq) begin
        r_mem[r_wptr] <= w_code;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_deq) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign lnk.quat_comp = r_comp;
  assign lnk.out_data  = r_mem[r_rptr];
  assign lnk.out_valid = (r_level != '0);
  assign fifo_level    = r_level;
endmodule
`default_nettype wire

// File: tb/tb_quat_sync_sink.sv
`default_nettype none
// ============================================================================
// tb_quat_sync_sink : scoreboard bench for quat_sync_sink with random traffic
// Revision: 1.0
// ============================================================================
module tb_quat_sync_sink;
  localparam int DEPTH  = 4;
  localparam int STABLE = 2;
  localparam int CNT_W  = 4;
  localparam int LAT    = 2 + STABLE + 1;
  localparam int TMO    = 200;

  logic                   clk = 1'b0;
  logic                   init_n = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   err_illegal;
  logic [CNT_W-1:0]       wave_cnt;

  quat_sync_sink_if lnk();

  quat_sync_sink #(.DEPTH(DEPTH), .STABLE(STABLE), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .init_n      (init_n),
    .lnk         (lnk),
    .fifo_level  (fifo_level),
    .err_illegal (err_illegal),
    .wave_cnt    (wave_cnt)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [1:0] exp_q[$];
  int         model_cnt = 0;
  int         model_err = 0;
  bit         rnd_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int rail_idx(input logic [3:0] p);
    for (int k = 0; k < 4; k++) if (p[k]) return k;
    return 0;
  endfunction

  // Scoreboard monitor: every accepted head must match the oldest expected value
  always @(negedge clk) begin
    if (init_n && lnk.out_valid && lnk.out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
      else chk("out_data", int'(lnk.out_data), int'(exp_q.pop_front()));
    end
  end

  task automatic wait_comp(input logic v, input string name);
    int n = 0;
    while (lnk.quat_comp !== v && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(lnk.quat_comp === v), 1);
  endtask

  task automatic model_issue(input logic [3:0] pat);
    if ($onehot(pat)) begin
      exp_q.push_back(2'(rail_idx(pat)));
      model_cnt++;
    end else if (pat != 4'd0) begin
      model_err = 1;
    end
  endtask

  task automatic send(input logic [3:0] pat);
    model_issue(pat);
    @(negedge clk);
    lnk.quat_in = pat;
    wait_comp(1'b1, "comp_rise");
    chk("wave_cnt", int'(wave_cnt), model_cnt % (1 << CNT_W));
    chk("err_illegal", int'(err_illegal), model_err);
    lnk.quat_in = 4'd0;
    wait_comp(1'b0, "comp_fall");
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk);
    #1 lnk.out_ready = 1'b1;
    while (fifo_level != 0 && n < TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_level", int'(fifo_level), 0);
    chk("drain_queue", exp_q.size(), 0);
    lnk.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat;
    int         lvl0;

    lnk.quat_in   = 4'd0;
    lnk.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_comp", int'(lnk.quat_comp), 0);
    chk("rst_valid", int'(lnk.out_valid), 0);
    chk("rst_data", int'(lnk.out_data), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_err", int'(err_illegal), 0);
    chk("rst_wave", int'(wave_cnt), 0);
    init_n = 1'b1;
    repeat (5) @(negedge clk);

    // Edge-to-completion latency in both directions
    @(posedge clk);
    #1;
    lnk.out_ready = 1'b1;
    model_issue(4'b0100);
    lnk.quat_in = 4'b0100;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk);
      #1;
      if (i == LAT - 1) chk("lat_rise_early", int'(lnk.quat_comp), 0);
      if (i == LAT) begin
        chk("lat_rise", int'(lnk.quat_comp), 1);
        chk("lat_valid", int'(lnk.out_valid), 1);
        chk("lat_wave", int'(wave_cnt), 1);
      end
    end
    lnk.quat_in = 4'd0;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk);
      #1;
      if (i == LAT - 1) chk("lat_fall_early", int'(lnk.quat_comp), 1);
      if (i == LAT) chk("lat_fall", int'(lnk.quat_comp), 0);
    end
    lnk.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Fill to DEPTH, then a fifth wavefront must be held off
    send(4'b0001);
    send(4'b0010);
    send(4'b1000);
    send(4'b0100);
    chk("full_level", int'(fifo_level), DEPTH);
    model_issue(4'b0001);
    @(negedge clk);
    lnk.quat_in = 4'b0001;
    repeat (12) @(negedge clk);
    chk("full_comp_held", int'(lnk.quat_comp), 0);
    chk("full_level_held", int'(fifo_level), DEPTH);
    chk("full_wave_held", int'(wave_cnt), (model_cnt - 1) % (1 << CNT_W));
    @(posedge clk);
    #1 lnk.out_ready = 1'b1;
    @(posedge clk);
    #1 lnk.out_ready = 1'b0;
    chk("full_swap_comp", int'(lnk.quat_comp), 1);
    chk("full_swap_level", int'(fifo_level), DEPTH);
    chk("full_swap_wave", int'(wave_cnt), model_cnt % (1 << CNT_W));
    lnk.quat_in = 4'd0;
    wait_comp(1'b0, "full_comp_fall");
    drain();

    // Illegal two-rail codeword is dropped but still completes
    lvl0 = int'(fifo_level);
    send(4'b0110);
    chk("illegal_level", int'(fifo_level), lvl0);
    send(4'b1000);
    drain();

    // Single-cycle glitch must not be taken
    @(posedge clk);
    #1 lnk.quat_in = 4'b0001;
    @(posedge clk);
    #1 lnk.quat_in = 4'b0000;
    repeat (10) @(negedge clk);
    chk("glitch_comp", int'(lnk.quat_comp), 0);
    chk("glitch_level", int'(fifo_level), 0);
    chk("glitch_wave", int'(wave_cnt), model_cnt % (1 << CNT_W));

    // Asynchronous reset with completion high and two entries buffered
    send(4'b0010);
    model_issue(4'b0001);
    @(negedge clk);
    lnk.quat_in = 4'b0001;
    wait_comp(1'b1, "pre_rst_comp");
    chk("pre_rst_level", int'(fifo_level), 2);
    @(negedge clk);
    #2 init_n = 1'b0;
    #1;
    chk("arst_comp", int'(lnk.quat_comp), 0);
    chk("arst_valid", int'(lnk.out_valid), 0);
    chk("arst_level", int'(fifo_level), 0);
    chk("arst_err", int'(err_illegal), 0);
    chk("arst_wave", int'(wave_cnt), 0);
    exp_q.delete();
    model_cnt = 0;
    model_err = 0;
    lnk.quat_in = 4'd0;
    repeat (3) @(negedge clk);
    init_n = 1'b1;
    repeat (5) @(negedge clk);

    // Random traffic with random backpressure; enough accepts to wrap the counter
    fork
      begin
        int legal = 0;
        int iter = 0;
        while (legal < 18 && iter < 60) begin
          if ($urandom_range(0, 7) == 0) begin
            pat = 4'(4'b0011 << $urandom_range(0, 2)) | 4'(1 << $urandom_range(0, 3));
          end else begin
            pat = 4'(1 << $urandom_range(0, 3));
            legal++;
          end
          send(pat);
          iter++;
        end
        chk("wrap_seen", int'(model_cnt >= (1 << CNT_W)), 1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 lnk.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    chk("final_wave", int'(wave_cnt), model_cnt % (1 << CNT_W));
    chk("final_err", int'(err_illegal), model_err);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/quat_sync_sink.md
Name: quat_sync_sink

Overview:
- Clocked receiver stage directly downstream of the binary+trinary→quaternary adder.
- Consumes the 1-of-4 quaternary DATA/NULL wavefronts and generates the completion signal that drives the adder's output-link enable, in place of the auto-consume TH14.
- Decodes each accepted wavefront to a 2-bit value and buffers it in a small FIFO with a valid/ready interface toward synchronous logic.
- Provides illegal-codeword detection and a wavefront counter for debug.

Parameters:
- DEPTH, 4, FIFO entries. Power of two, ≥2.
- STABLE, 2, consecutive synchronized cycles a rail pattern must hold before it is acted on. ≥1.
- CNT_W, 16, width of the accepted-wavefront counter.

Ports:
- clk  in  1  single clock.
- init_n  in  1  asynchronous active-low reset.
- quat_in  in  4  1-of-4 rails from the adder; bit k high = value k; all low = NULL.
- quat_comp  out  1  completion to upstream. 1 = DATA consumed, request NULL. 0 = request DATA.
- out_data  out  2  decoded value at FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid & out_ready at a clk edge.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- err_illegal  out  1  sticky; set when >1 rail is stable high.
- wave_cnt  out  CNT_W  count of DATA wavefronts enqueued; wraps at 2^CNT_W.

Behaviour:
- Reset (init_n=0, asynchronous): quat_comp=0, out_valid=0, out_data=0, fifo_level=0, err_illegal=0, wave_cnt=0, FSM=WAIT_DATA, synchronizers and stability counter cleared.
- Reset asserted mid-handshake: quat_comp drops immediately, regardless of clk. Buffered data is discarded.
- Input path: quat_in passes through a 2-flop synchronizer per rail. A pattern is "stable" when the synchronized value is unchanged for STABLE consecutive cycles. The stability counter restarts on any change.
- FSM states:
  - WAIT_DATA (quat_comp=0):
    - Stable one-hot pattern and FIFO not full → enqueue the encoded index (rail0→0 … rail3→3), increment wave_cnt, go to WAIT_NULL. quat_comp=1 from the next cycle.
    - Stable one-hot pattern and FIFO full → stay, quat_comp held 0. This backpressures upstream; the data is enqueued once space frees.
    - Stable pattern with ≥2 rails high → set err_illegal, enqueue nothing, go to WAIT_NULL. The wavefront is dropped so the handshake cannot deadlock.
    - All-zero pattern → stay.
  - WAIT_NULL (quat_comp=1):
    - Stable all-zero pattern → go to WAIT_DATA. quat_comp=0 from the next cycle.
    - Non-zero patterns, legal or not, are ignored.
- Minimum latency from a quat_in DATA edge to quat_comp rising: 2 synchronizer cycles + STABLE cycles + 1 register cycle.
- FIFO:
  - First-word-fall-through. out_data is valid the cycle after enqueue.
  - Simultaneous enqueue and dequeue is allowed at any level, including full. When full, the dequeue frees the slot and the enqueue proceeds in the same cycle; fifo_level stays unchanged.
  - Pointers wrap modulo DEPTH.
- out_data holds its value while out_valid=0. Its value when empty is don't-care; the bench checks it only when out_valid=1.
- err_illegal clears only on reset.

Test Plan:
- Reset, then quat_in=0100 held, out_ready=1 → after 2+STABLE+1 cycles quat_comp=1, out_valid=1, out_data=2, wave_cnt=1. Drop quat_in to 0000 → quat_comp=0 after 2+STABLE+1 cycles.
- Sequence of wavefronts 0001,0010,1000,0100 with NULLs between and out_ready=0, DEPTH=4 → fifo_level=4. A fifth wavefront 0001 leaves quat_comp=0. Pulse out_ready for one cycle → out_data=0 dequeued, fifth value enqueued, quat_comp=1, fifo_level stays 4.
- quat_in=0110 held → err_illegal=1, quat_comp=1, fifo_level unchanged, wave_cnt unchanged. Release to 0000 → quat_comp=0. Subsequent 1000 is accepted normally with out_data=3.
- Glitch: quat_in=0001 for STABLE-1 synchronized cycles then back to 0000 → no enqueue, quat_comp stays 0.
- Assert init_n=0 while quat_comp=1 and fifo_level=2 → quat_comp, out_valid and fifo_level go to 0 with no clk edge. After release, normal operation resumes.
- Preload wave_cnt near 2^CNT_W-1 with CNT_W=4 (16 wavefronts) → wave_cnt wraps to 0. FIFO pointers wrap with no data loss, all 16 values read back in order.
